// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit controller between decode and a single-port data memory
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ram_read, ram_write      load/store request levels from decode (sampled in IDLE)
//   load_type                00 LW, 01 LH, 10 LB, 11 unsupported
//   addr, store_data         byte address and store value
//   mem_req, mem_we          memory request / write enable
//   mem_addr                 word-aligned memory address
//   mem_wdata, mem_wstrb     store data and byte enables
//   mem_ready, mem_rdata     memory accept/complete and read word
//   load_data                sign-extended load result, held until next completed load
//   done                     one-cycle completion pulse
//   stall                    pipeline hold
//   err, err_code            one-cycle error pulse; 01 misaligned, 10 bad type/conflict, 11 timeout
module lsu_ctrl #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_read,
    input  logic        ram_write,
    input  logic [1:0]  load_type,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic [31:0] load_data,
    output logic        done,
    output logic        stall,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_WAIT = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t state, state_next;

    logic [29:0]   word_q;
    logic [1:0]    lane_q;
    logic [1:0]    type_q;
    logic          we_q;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic [31:0]   load_data_q;
    logic          err_q;
    logic [1:0]    err_code_q;
    logic [CW-1:0] wait_cnt;

    logic       rd_only, wr_only, both;
    logic       rd_aligned, bad_type, legal, misaligned;
    logic [15:0] half;
    logic [7:0]  byte_sel;
    logic [31:0] extracted;

    // Request classification, only acted on while IDLE
    always_comb begin
        rd_only = ram_read & ~ram_write;
        wr_only = ram_write & ~ram_read;
        both    = ram_read & ram_write;
        case (load_type)
            2'b00:   rd_aligned = (addr[1:0] == 2'b00);
            2'b01:   rd_aligned = ~addr[0];
            2'b10:   rd_aligned = 1'b1;
            default: rd_aligned = 1'b0;
        endcase
        bad_type   = rd_only & (load_type == 2'b11);
        legal      = (rd_only & ~bad_type & rd_aligned) | (wr_only & (addr[1:0] == 2'b00));
        misaligned = (rd_only & ~bad_type & ~rd_aligned) | (wr_only & (addr[1:0] != 2'b00));
    end

    // Lane extraction from the returned word using the latched byte offset
    always_comb begin
        half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (lane_q)
            2'b00:   byte_sel = mem_rdata[7:0];
            2'b01:   byte_sel = mem_rdata[15:8];
            2'b10:   byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        case (type_q)
            2'b01:   extracted = {{16{half[15]}}, half};
            2'b10:   extracted = {{24{byte_sel[7]}}, byte_sel};
            default: extracted = mem_rdata;
        endcase
    end

    always_comb begin
        state_next = state;
        stall      = 1'b0;
        case (state)
            IDLE: begin
                if (legal) begin
                    stall      = 1'b1;
                    state_next = REQ;
                end
            end
            REQ: begin
                stall = 1'b1;
                if (mem_ready)
                    state_next = RESP;
                else if (wait_cnt == LAST_WAIT)
                    state_next = IDLE;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            word_q      <= '0;
            lane_q      <= '0;
            type_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            load_data_q <= '0;
            err_q       <= 1'b0;
            err_code_q  <= 2'b00;
            wait_cnt    <= '0;
        end else begin
            state      <= state_next;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            case (state)
                IDLE: begin
                    if (legal) begin
                        word_q   <= addr[31:2];
                        lane_q   <= addr[1:0];
                        type_q   <= load_type;
                        we_q     <= wr_only;
                        wdata_q  <= store_data;
                        wstrb_q  <= wr_only ? 4'b1111 : 4'b0000;
                        wait_cnt <= '0;
                    end else if (misaligned) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b01;
                    end else if (bad_type | both) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b10;
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!we_q)
                            load_data_q <= extracted;
                    end else if (wait_cnt == LAST_WAIT) begin
                        err_q      <= 1'b1;
                        err_code_q <= 2'b11;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req   = (state == REQ);
    assign done      = (state == RESP);
    assign mem_we    = we_q;
    assign mem_addr  = {word_q, 2'b00};
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign load_data = load_data_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed vector bench for lsu_ctrl
module tb_lsu_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        ram_read, ram_write;
    logic [1:0]  load_type;
    logic [31:0] addr, store_data;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] load_data;
    logic        done, stall, err;
    logic [1:0]  err_code;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    lsu_ctrl #(.TIMEOUT(255)) dut (
        .clk(clk), .rst(rst),
        .ram_read(ram_read), .ram_write(ram_write),
        .load_type(load_type), .addr(addr), .store_data(store_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .load_data(load_data), .done(done), .stall(stall),
        .err(err), .err_code(err_code)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [1:0]  ltype;
        logic [31:0] a;
        logic [31:0] sdata;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  exp_code;
        logic [31:0] exp_ld;
        logic [31:0] exp_maddr;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ram_read   = 1'b0;
        ram_write  = 1'b0;
        load_type  = 2'b00;
        addr       = '0;
        store_data = '0;
        mem_ready  = 1'b0;
        mem_rdata  = '0;
    endtask

    task automatic run_vec(input vec_t v);
        ram_read   = v.rd;
        ram_write  = v.wr;
        load_type  = v.ltype;
        addr       = v.a;
        store_data = v.sdata;
        #1;
        chk("stall_on_request", {31'd0, stall}, {31'd0, (v.exp_code == 2'b00)});
        tick();
        ram_read  = 1'b0;
        ram_write = 1'b0;
        addr      = 32'hFFFF_FFFF;
        store_data = 32'h0BAD_0BAD;
        if (v.exp_code != 2'b00) begin
            chk("err_pulse", {31'd0, err}, 32'd1);
            chk("err_code", {30'd0, err_code}, {30'd0, v.exp_code});
            chk("no_mem_req_on_err", {31'd0, mem_req}, 32'd0);
            tick();
            chk("err_cleared", {29'd0, err, err_code}, 32'd0);
        end else begin
            for (int i = 0; i < v.delay; i++) begin
                chk("mem_req_wait", {31'd0, mem_req}, 32'd1);
                chk("mem_addr_wait", mem_addr, v.exp_maddr);
                chk("mem_we_wait", {31'd0, mem_we}, {31'd0, v.wr});
                chk("mem_wstrb_wait", {28'd0, mem_wstrb}, v.wr ? 32'hF : 32'h0);
                if (v.wr) chk("mem_wdata_wait", mem_wdata, v.sdata);
                chk("no_done_wait", {31'd0, done}, 32'd0);
                tick();
            end
            mem_ready = 1'b1;
            mem_rdata = v.rdata;
            #1;
            chk("mem_req_ready", {31'd0, mem_req}, 32'd1);
            chk("mem_addr_ready", mem_addr, v.exp_maddr);
            chk("stall_in_req", {31'd0, stall}, 32'd1);
            tick();
            mem_ready = 1'b0;
            mem_rdata = 32'h5555_AAAA;
            chk("done_pulse", {31'd0, done}, 32'd1);
            chk("mem_req_dropped", {31'd0, mem_req}, 32'd0);
            chk("stall_in_resp", {31'd0, stall}, 32'd0);
            chk("load_data", load_data, v.exp_ld);
            tick();
            chk("done_cleared", {31'd0, done}, 32'd0);
            chk("load_data_hold", load_data, v.exp_ld);
        end
    endtask

    int waits;

    initial begin
        //          rd    wr    type   addr          sdata          dly rdata          code   exp_ld         exp_maddr
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_1003, 32'h0,         2, 32'h80FF_1234, 2'b00, 32'hFFFF_FF80, 32'h0000_1000};
        vecs[1]  = '{1'b1, 1'b0, 2'b01, 32'h0000_2002, 32'h0,         0, 32'h7FFF_8000, 2'b00, 32'h0000_7FFF, 32'h0000_2000};
        vecs[2]  = '{1'b1, 1'b0, 2'b01, 32'h0000_2000, 32'h0,         1, 32'h7FFF_8000, 2'b00, 32'hFFFF_8000, 32'h0000_2000};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 32'h0000_3000, 32'hDEAD_BEEF, 3, 32'h0,         2'b00, 32'hFFFF_8000, 32'h0000_3000};
        vecs[4]  = '{1'b1, 1'b0, 2'b00, 32'h0000_0002, 32'h0,         0, 32'h0,         2'b01, 32'h0,         32'h0};
        vecs[5]  = '{1'b1, 1'b1, 2'b00, 32'h0000_4000, 32'h0,         0, 32'h0,         2'b10, 32'h0,         32'h0};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h0000_4001, 32'h0,         0, 32'h1234_5678, 2'b00, 32'h0000_0056, 32'h0000_4000};
        vecs[7]  = '{1'b1, 1'b0, 2'b00, 32'h0000_5004, 32'h0,         1, 32'hA5A5_0F0F, 2'b00, 32'hA5A5_0F0F, 32'h0000_5004};
        vecs[8]  = '{1'b1, 1'b0, 2'b11, 32'h0000_6000, 32'h0,         0, 32'h0,         2'b10, 32'h0,         32'h0};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 32'h0000_3002, 32'h1111_2222, 0, 32'h0,         2'b01, 32'h0,         32'h0};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 32'h0000_6001, 32'h0,         0, 32'h0,         2'b01, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 1'b0, 2'b10, 32'h0000_7002, 32'h0,         2, 32'h0080_0000, 2'b00, 32'hFFFF_FF80, 32'h0000_7000};

        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        chk("rst_load_data", load_data, 32'd0);
        chk("rst_flags", {28'd0, done, stall, err, 1'b0}, 32'd0);
        chk("rst_err_code", {30'd0, err_code}, 32'd0);

        for (int i = 0; i < 12; i++)
            run_vec(vecs[i]);

        // Timeout: memory never answers
        ram_read  = 1'b1;
        load_type = 2'b00;
        addr      = 32'h0000_0100;
        tick();
        ram_read = 1'b0;
        waits = 0;
        while (mem_req && waits < 400) begin
            if (waits == 10) ram_write = 1'b1;
            chk("timeout_no_done", {31'd0, done}, 32'd0);
            waits++;
            tick();
        end
        ram_write = 1'b0;
        chk("timeout_wait_cycles", waits, 255);
        chk("timeout_err", {31'd0, err}, 32'd1);
        chk("timeout_err_code", {30'd0, err_code}, 32'd3);
        chk("timeout_no_done_end", {31'd0, done}, 32'd0);
        tick();
        chk("timeout_err_cleared", {29'd0, err, err_code}, 32'd0);
        chk("timeout_no_done_after", {31'd0, done}, 32'd0);
        chk("timeout_no_restart", {31'd0, mem_req}, 32'd0);

        // Reset while a store is outstanding
        ram_write  = 1'b1;
        addr       = 32'h0000_8000;
        store_data = 32'hCAFE_F00D;
        tick();
        idle_inputs();
        tick();
        chk("pre_rst_mem_req", {31'd0, mem_req}, 32'd1);
        chk("pre_rst_mem_we", {31'd0, mem_we}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("mid_rst_mem_we", {31'd0, mem_we}, 32'd0);
        chk("mid_rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
        chk("mid_rst_mem_addr", mem_addr, 32'd0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'd0);
        chk("mid_rst_load_data", load_data, 32'd0);
        chk("mid_rst_flags", {29'd0, done, stall, err}, 32'd0);
        tick();
        chk("post_rst_quiet", {28'd0, done, err, err_code}, 32'd0);
        run_vec('{1'b1, 1'b0, 2'b00, 32'h0000_9008, 32'h0, 1, 32'h1357_9BDF, 2'b00, 32'h1357_9BDF, 32'h0000_9008});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
